// File: rtl/vx_cluster_mem_arb.sv
// vx_cluster_mem_arb: round-robin merge of cluster L2 memory ports into one
// memory port, with a 2-entry request buffer and tag-routed responses.
module vx_cluster_mem_arb #(
  parameter  int NUM_REQS      = 4,
  parameter  int ADDR_WIDTH    = 26,
  parameter  int DATA_WIDTH    = 512,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int MAX_PENDING   = 16,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int LOG_REQS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS,
  localparam int CNT_W         = $clog2(MAX_PENDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS-1:0]              req_rw,
  output logic [NUM_REQS-1:0]              req_ready,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]              rsp_valid,
  input  logic [NUM_REQS-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          rsp_tag,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy
);

  typedef struct packed {
    logic                     rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [BYTEEN_WIDTH-1:0]  byteen;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } ent_t;

  logic [LOG_REQS-1:0] r_ptr;
  logic [CNT_W-1:0]    r_pend [NUM_REQS];
  ent_t                r_q [2];
  logic                r_wr;
  logic                r_rd;
  logic [1:0]          r_cnt;

  logic [NUM_REQS-1:0] w_elig;
  logic                w_any;
  logic                w_push;
  logic                w_pop;
  logic [LOG_REQS-1:0] w_win;
  logic [LOG_REQS-1:0] w_nxt;
  ent_t                w_ent;
  logic [LOG_REQS-1:0] w_ridx;
  logic                w_rok;
  logic                w_rfire;
  logic [NUM_REQS-1:0] w_inc;
  logic [NUM_REQS-1:0] w_dec;
  logic                w_pnz;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_elig[i] = req_valid[i] &
        (req_rw[i] | (r_pend[i] < CNT_W'(MAX_PENDING)));
    end
  end

  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = (int'(r_ptr) + k) % NUM_REQS;
      if (!w_any && w_elig[LOG_REQS'(j)]) begin
        w_any = 1'b1;
        w_win = LOG_REQS'(j);
      end
    end
  end

  assign w_nxt  = (int'(w_win) == NUM_REQS - 1) ? '0 : w_win + 1'b1;
  assign w_push = reset & w_any & ~r_cnt[1];
  assign w_pop  = (r_cnt != 2'd0) & mem_req_ready;

  always_comb begin
    req_ready = '0;
    if (w_push) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_ent.rw     = req_rw[w_win];
    w_ent.addr   = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    w_ent.data   = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    w_ent.byteen = req_byteen[w_win*BYTEEN_WIDTH +: BYTEEN_WIDTH];
    w_ent.tag    = {req_tag[w_win*TAG_IN_WIDTH +: TAG_IN_WIDTH], w_win};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 2'd0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_ptr <= '0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop) r_rd <= ~r_rd;
      if (w_push) r_ptr <= w_nxt;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= w_ent;
  end

  assign mem_req_valid  = (r_cnt != 2'd0);
  assign mem_req_rw     = r_q[r_rd].rw;
  assign mem_req_addr   = r_q[r_rd].addr;
  assign mem_req_data   = r_q[r_rd].data;
  assign mem_req_byteen = r_q[r_rd].byteen;
  assign mem_req_tag    = r_q[r_rd].tag;

  assign w_ridx = mem_rsp_tag[LOG_REQS-1:0];

  if (NUM_REQS == (1 << LOG_REQS)) begin : g_rok_full
    assign w_rok = 1'b1;
  end else begin : g_rok_part
    assign w_rok = ({{(32-LOG_REQS){1'b0}}, w_ridx} < 32'(NUM_REQS));
  end

  // responses to a nonexistent requester are consumed and dropped
  always_comb begin
    rsp_valid     = '0;
    mem_rsp_ready = 1'b1;
    if (w_rok) begin
      rsp_valid[w_ridx] = mem_rsp_valid;
      mem_rsp_ready     = rsp_ready[w_ridx];
    end
  end

  assign rsp_tag  = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS];
  assign rsp_data = mem_rsp_data;
  assign w_rfire  = mem_rsp_valid & mem_rsp_ready & w_rok;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_inc[i] = w_push & ~w_ent.rw & (w_win == LOG_REQS'(i));
      w_dec[i] = w_rfire & (w_ridx == LOG_REQS'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (w_inc[i] & ~w_dec[i])
          r_pend[i] <= r_pend[i] + 1'b1;
        else if (w_dec[i] & ~w_inc[i] & (r_pend[i] != '0))
          r_pend[i] <= r_pend[i] - 1'b1;
      end
    end
  end

  always_comb begin
    w_pnz = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (r_pend[i] != '0) w_pnz = 1'b1;
    end
  end

  assign busy = (r_cnt != 2'd0) | w_pnz;

endmodule

// File: tb/tb_vx_cluster_mem_arb.sv
// tb_vx_cluster_mem_arb: randomized scoreboard bench for the cluster memory
// arbiter against a queue-based round-robin reference model.
module tb_vx_cluster_mem_arb;
  localparam int N    = 4;
  localparam int AW   = 26;
  localparam int DW   = 512;
  localparam int BW   = 64;
  localparam int TW   = 8;
  localparam int LW   = 2;
  localparam int TOW  = 10;
  localparam int MAXP = 16;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    req_valid, req_rw, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_byteen;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic            mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [BW-1:0]   mem_req_byteen;
  logic [TOW-1:0]  mem_req_tag;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]   mem_rsp_data;
  logic [TOW-1:0]  mem_rsp_tag;
  logic            busy;

  vx_cluster_mem_arb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .req_byteen(req_byteen), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rw;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [BW-1:0]  be;
    logic [TOW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  bit            hv  [N];
  logic          hrw [N];
  logic [AW-1:0] ha  [N];
  logic [DW-1:0] hd  [N];
  logic [BW-1:0] hb  [N];
  logic [TW-1:0] ht  [N];

  int pend [N];
  int ptr;
  int fifo_n;
  int n_vec;
  int n_err;

  int p_new, p_wr, p_mrdy, p_rsp, p_rrdy;
  logic [N-1:0] req_mask, rsp_mask;

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic cycle();
    int            w;
    int            ri;
    bit            gr, pop, fire, anyb;
    logic [N-1:0]  exp_rr, ev;
    logic [TW-1:0] rt;
    logic [DW-1:0] rd;
    exp_t          e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!req_mask[i]) hv[i] = 1'b0;
      if (!hv[i] && req_mask[i] && pct(p_new)) begin
        hv[i]  = 1'b1;
        hrw[i] = pct(p_wr);
        ha[i]  = AW'($urandom);
        hd[i]  = rnd_line();
        hb[i]  = {$urandom, $urandom};
        ht[i]  = TW'($urandom);
      end
      req_valid[i]            = hv[i];
      req_rw[i]               = hrw[i];
      req_addr[i*AW +: AW]    = ha[i];
      req_data[i*DW +: DW]    = hd[i];
      req_byteen[i*BW +: BW]  = hb[i];
      req_tag[i*TW +: TW]     = ht[i];
      rsp_ready[i]            = pct(p_rrdy);
    end
    mem_req_ready = pct(p_mrdy);
    ri = $urandom_range(N-1);
    for (int k = 0; k < N && !rsp_mask[ri]; k++) ri = (ri + 1) % N;
    rt = TW'($urandom);
    rd = rnd_line();
    mem_rsp_valid = (rsp_mask != '0) && pct(p_rsp);
    mem_rsp_tag   = {rt, LW'(ri)};
    mem_rsp_data  = rd;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (w < 0 && hv[j] && (hrw[j] || pend[j] < MAXP)) w = j;
    end
    gr = reset && (w >= 0) && (fifo_n < 2);
    exp_rr = gr ? (N'(1) << w) : '0;
    chk("req_ready", DW'(req_ready), DW'(exp_rr));
    chk("mem_req_valid", DW'(mem_req_valid), DW'(fifo_n > 0));
    anyb = fifo_n > 0;
    for (int i = 0; i < N; i++) if (pend[i] != 0) anyb = 1'b1;
    chk("busy", DW'(busy), DW'(anyb));
    ev = mem_rsp_valid ? (N'(1) << ri) : '0;
    chk("rsp_valid", DW'(rsp_valid), DW'(ev));
    chk("mem_rsp_ready", DW'(mem_rsp_ready), DW'(rsp_ready[ri]));
    if (mem_rsp_valid) begin
      chk("rsp_tag", DW'(rsp_tag), DW'(rt));
      chk("rsp_data", rsp_data, rd);
    end
    pop  = (fifo_n > 0) && mem_req_ready;
    fire = mem_rsp_valid && rsp_ready[ri];
    for (int i = 0; i < N; i++) begin
      bit inc, dec;
      inc = gr && !hrw[w] && (i == w);
      dec = fire && (i == ri);
      if (inc && !dec) pend[i]++;
      else if (dec && !inc && pend[i] > 0) pend[i]--;
    end
    if (gr) begin
      e.rw   = hrw[w];
      e.addr = ha[w];
      e.data = hd[w];
      e.be   = hb[w];
      e.tag  = {ht[w], LW'(w)};
      exp_q.push_back(e);
      hv[w] = 1'b0;
      ptr   = (w + 1) % N;
    end
    fifo_n = fifo_n - int'(pop) + int'(gr);
  endtask

  task automatic knobs(input logic [N-1:0] rm, input int pn, input int pw,
                       input int pm, input int pr, input int prr,
                       input logic [N-1:0] sm);
    req_mask = rm; p_new = pn; p_wr = pw; p_mrdy = pm;
    p_rsp = pr; p_rrdy = prr; rsp_mask = sm;
  endtask

  // memory-side monitor: checks the buffer head against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && mem_req_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mem_req_unexpected: got tag %0h expected none",
                   mem_req_tag);
        end else begin
          chk("mem_req_rw", DW'(mem_req_rw), DW'(exp_q[0].rw));
          chk("mem_req_addr", DW'(mem_req_addr), DW'(exp_q[0].addr));
          chk("mem_req_data", mem_req_data, exp_q[0].data);
          chk("mem_req_byteen", DW'(mem_req_byteen), DW'(exp_q[0].be));
          chk("mem_req_tag", DW'(mem_req_tag), DW'(exp_q[0].tag));
          if (mem_req_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit left;
    n_vec = 0; n_err = 0; ptr = 0; fifo_n = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; hv[i] = 1'b0; hrw[i] = 1'b0;
      ha[i] = '0; hd[i] = '0; hb[i] = '0; ht[i] = '0;
    end
    knobs('0, 0, 0, 0, 0, 0, '0);
    reset = 1'b0;
    req_valid = '1; req_rw = '0; req_addr = '0; req_data = '0;
    req_byteen = '0; req_tag = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {8'hA5, 2'd2};
    mem_rsp_data  = rnd_line();
    rsp_ready     = 4'b1011;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_mem_req_valid", DW'(mem_req_valid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(4'b0100));
    chk("rst_rsp_tag", DW'(rsp_tag), DW'(8'hA5));
    chk("rst_mem_rsp_ready", DW'(mem_rsp_ready), DW'(0));
    rsp_ready[2] = 1'b1;
    #1;
    chk("rst_mem_rsp_ready_hi", DW'(mem_rsp_ready), DW'(1));
    mem_rsp_valid = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;

    // all four reading back to back with memory always ready
    knobs('1, 100, 0, 100, 0, 0, '0);
    repeat (12) cycle();
    // two requesters against a stalled memory port
    knobs('0, 0, 0, 100, 0, 0, '0);
    repeat (2) cycle();
    knobs(4'b0110, 100, 0, 0, 0, 0, '0);
    repeat (6) cycle();
    knobs(4'b0110, 100, 0, 100, 0, 0, '0);
    repeat (4) cycle();
    // requester 0 runs into its outstanding-read limit
    knobs(4'b0001, 100, 0, 100, 0, 0, '0);
    repeat (25) cycle();
    hrw[0] = 1'b1;
    repeat (2) cycle();
    hrw[0] = 1'b0;
    repeat (2) cycle();
    knobs(4'b0001, 100, 0, 100, 100, 100, 4'b0001);
    cycle();
    knobs(4'b0001, 100, 0, 100, 0, 0, '0);
    repeat (3) cycle();
    // random traffic
    knobs('1, 60, 30, 70, 50, 70, '1);
    repeat (1500) cycle();
    // asynchronous reset with requests buffered and reads outstanding
    knobs('1, 100, 0, 0, 0, 0, '0);
    repeat (4) cycle();
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_mem_req_valid", DW'(mem_req_valid), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_req_ready", DW'(req_ready), DW'(0));
    exp_q.delete();
    fifo_n = 0;
    ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    knobs('1, 100, 0, 100, 0, 0, '0);
    repeat (8) cycle();
    // drain everything outstanding
    for (int c = 0; c < 400; c++) begin
      left = fifo_n > 0;
      for (int i = 0; i < N; i++) begin
        rsp_mask[i] = pend[i] > 0;
        if (pend[i] > 0) left = 1'b1;
      end
      if (!left) break;
      req_mask = '0; p_mrdy = 100; p_rsp = 100; p_rrdy = 100;
      cycle();
    end
    knobs('0, 0, 0, 100, 0, 0, '0);
    repeat (2) cycle();
    #1;
    chk("end_busy", DW'(busy), DW'(0));
    chk("end_mem_req_valid", DW'(mem_req_valid), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vx_cluster_mem_arb.md
VX_CLUSTER_MEM_ARB -- requirements
Module: VX_cluster_mem_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of cluster L2 memory ports merged (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, line address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, line data width; BYTEEN_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter TAG_IN_WIDTH, default 8, per-requester tag width; LOG_REQS = max(1, clog2(NUM_REQS)); TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS.
REQ-005 SHALL have parameter MAX_PENDING, default 16, max outstanding reads per requester; CNT_W = clog2(MAX_PENDING+1).
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 req_valid / req_rw / req_ready  input/input/output  NUM_REQS each  per-requester request handshake; rw=1 write.
REQ-009 req_addr / req_data / req_byteen / req_tag  input  NUM_REQS x (ADDR_WIDTH / DATA_WIDTH / BYTEEN_WIDTH / TAG_IN_WIDTH), flattened, index i at slice i.
REQ-010 rsp_valid / rsp_ready  output/input  NUM_REQS each  per-requester response handshake.
REQ-011 rsp_data / rsp_tag  output  DATA_WIDTH / TAG_IN_WIDTH  shared response payload, valid for asserted rsp_valid bit.
REQ-012 mem_req_valid, mem_req_rw  output 1; mem_req_addr/data/byteen  output ADDR_WIDTH/DATA_WIDTH/BYTEEN_WIDTH; mem_req_tag  output TAG_OUT_WIDTH; mem_req_ready  input 1.
REQ-013 mem_rsp_valid  input 1; mem_rsp_data  input DATA_WIDTH; mem_rsp_tag  input TAG_OUT_WIDTH; mem_rsp_ready  output 1.
REQ-014 busy  output  1  any request buffered or any read outstanding.

Function
REQ-015 Requester i SHALL be eligible when req_valid[i]=1 and (req_rw[i]=1 or pend_cnt[i] < MAX_PENDING).
REQ-016 Arbitration SHALL be round-robin: search starts at pointer p (reset 0); first eligible index i from p upward (wrapping) wins; on grant p <= (i+1) mod NUM_REQS; p unchanged when no grant.
REQ-017 Grant SHALL occur only when the 2-entry output buffer is not full; req_ready[i] = winner_is_i AND buffer_not_full; at most one req_ready bit high per cycle.
REQ-018 Accepted request SHALL be written to a 2-entry FIFO; mem_req_* driven from FIFO head; mem_req_valid = FIFO non-empty; fire-to-mem_req_valid latency exactly 1 cycle when FIFO empty.
REQ-019 mem_req_tag SHALL be {req_tag[i], i[LOG_REQS-1:0]} (index in LSBs); all other fields pass unmodified.
REQ-020 FIFO SHALL sustain 1 request/cycle when mem_req_ready held high; simultaneous push and pop at count 2 SHALL not be allowed (grant blocked when full, pop-then-push not bypassed).
REQ-021 mem_req_* SHALL be stable while mem_req_valid=1 and mem_req_ready=0.
REQ-022 Response route: idx = mem_rsp_tag[LOG_REQS-1:0]; rsp_valid[idx] = mem_rsp_valid, others 0; rsp_tag = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS]; rsp_data = mem_rsp_data; mem_rsp_ready = rsp_ready[idx]; zero-cycle combinational path.
REQ-023 idx >= NUM_REQS SHALL drive all rsp_valid 0 and mem_rsp_ready 1 (response dropped).
REQ-024 pend_cnt[i] SHALL increment on read grant to i, decrement on mem_rsp fire with idx=i; both same cycle -> unchanged; decrement at 0 -> stays 0 (no underflow).
REQ-025 busy SHALL equal (FIFO non-empty) OR (any pend_cnt != 0), registered-free combinational of state.

Reset
REQ-026 While reset=0: FIFO empty, p=0, all pend_cnt=0; hence mem_req_valid=0, req_ready=0, busy=0; rsp_* follow REQ-022 combinationally.
REQ-027 Reset assertion mid-transaction SHALL discard buffered requests and counters immediately (asynchronous); deassertion sampled synchronously, first grant possible in first cycle after release.

Verification
REQ-028 All 4 requesters valid reads each cycle, mem_req_ready=1 -> grants 0,1,2,3,0,... one per cycle; mem_req_tag LSBs follow same order, first at cycle 1 after first grant.
REQ-029 mem_req_ready=0 for 5 cycles with requesters 1,2 valid -> exactly 2 accepted, req_ready all 0 afterwards, mem_req_* fields constant until ready returns.
REQ-030 Requester 0 issues 16 reads, no responses -> 17th read stalled (req_ready[0]=0), write from requester 0 still granted; one response tag LSB=0 -> read accepted next arbitration.
REQ-031 mem_rsp_tag={8'hA5,2'd2}, rsp_ready[2]=0 -> rsp_valid=4'b0100, rsp_tag=8'hA5, mem_rsp_ready=0; raise rsp_ready[2] -> fire, pend_cnt[2] decrements.
REQ-032 Same-cycle read grant and response for requester 1 at pend_cnt=3 -> pend_cnt stays 3; busy falls only after FIFO empty and all counters 0.
REQ-033 Assert reset with 2 buffered requests and pend_cnt[3]=5 -> mem_req_valid=0 and busy=0 in same cycle, grants resume from index 0 after release.
